osc_param_writer: RTL

Control-side writer for the oscillator parameter port. Accepts one parameter-update request at a time from the control front end over a valid/ready handshake. Sequences frequency and amplitude writes onto the shared 8-bit parameter bus with per-field enables, then issues an arm pulse so the oscillator resumes stepping. Sits between the control/UI logic and each oscillators instance, and drives that instance's amplitude/freq bus, freq/amp enables and wave-type register.

---
 rtl/osc_pkg.sv | 23 ++
 rtl/osc_phase_timer.sv | 25 ++
 rtl/osc_param_writer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/osc_pkg.sv
// Shared definitions for the oscillator parameter writer: wave codes,
// request mask bit positions and the writer state encoding.
package osc_pkg;

  localparam logic [1:0] SQUARE           = 2'b00;
  localparam logic [1:0] TRIANGLE         = 2'b01;
  localparam logic [1:0] SAWTOOTH         = 2'b10;
  localparam logic [1:0] REVERSE_SAWTOOTH = 2'b11;

  localparam int MASK_FREQ = 0;
  localparam int MASK_AMP  = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_FREQ = 3'd1,
    GAP_F   = 3'd2,
    WR_AMP  = 3'd3,
    GAP_A   = 3'd4,
    ARM     = 3'd5,
    DONE    = 3'd6
  } wr_state_e;

endpackage

// File: rtl/osc_phase_timer.sv
// Loadable down-counter shared by the hold and gap phases. A phase lasting
// N cycles is loaded with N-1; the terminal flag is high in the last cycle.
// The count parks at zero instead of wrapping.
module osc_phase_timer #(
  parameter int CNT_W = 2
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_tc
);

  logic [CNT_W-1:0] cnt;

  // reload on phase entry, otherwise count down and hold at zero
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)      cnt <= '0;
    else if (i_load)     cnt <= i_load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign o_tc = (cnt == '0);

endmodule

// File: rtl/osc_param_writer.sv
// Sequences one parameter update onto the oscillator's shared bus:
// optional frequency write, optional amplitude write, each followed by an
// idle gap, then a single both-enables arm cycle and a done pulse.
// Outputs are registered as a function of the next state, so they change
// on the same edge as the state they belong to.
module osc_param_writer
  import osc_pkg::*;
#(
  parameter int OSC_WIDTH   = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [1:0]           i_req_mask,
  input  logic [OSC_WIDTH-1:0] i_req_freq,
  input  logic [OSC_WIDTH-1:0] i_req_amp,
  input  logic [1:0]           i_req_wave,
  output logic [OSC_WIDTH-1:0] o_amplitude_freq_reg,
  output logic                 o_freq_en,
  output logic                 o_amp_en,
  output logic [1:0]           o_wave_type_reg,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [OSC_WIDTH-1:0] o_cur_freq,
  output logic [OSC_WIDTH-1:0] o_cur_amp
);

  localparam int MAX_PH = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int PH_W   = $clog2(MAX_PH + 1);
  localparam logic [PH_W-1:0] HOLD_LD = PH_W'(HOLD_CYCLES - 1);
  localparam logic [PH_W-1:0] GAP_LD  = PH_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  wr_state_e            state, nxt;
  logic                 accept;
  logic                 ph_tc, ph_load;
  logic [PH_W-1:0]      ph_val;
  logic                 amp_pend;
  logic [OSC_WIDTH-1:0] freq_q, amp_q, freq_n, amp_n;
  logic [1:0]           wave_q, wave_n;

  assign accept = i_req_valid & o_req_ready;

  // payload as it will be seen after this edge (fresh on the accepting edge)
  assign freq_n = accept ? i_req_freq : freq_q;
  assign amp_n  = accept ? i_req_amp  : amp_q;
  assign wave_n = accept ? i_req_wave : wave_q;

  // next-state decode; each timed phase leaves on its terminal cycle
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (i_req_mask[MASK_FREQ])     nxt = WR_FREQ;
          else if (i_req_mask[MASK_AMP]) nxt = WR_AMP;
          else                           nxt = DONE;
        end
      end
      WR_FREQ: begin
        if (ph_tc) begin
          if (GAP_CYCLES > 0) nxt = GAP_F;
          else if (amp_pend)  nxt = WR_AMP;
          else                nxt = ARM;
        end
      end
      GAP_F: begin
        if (ph_tc) begin
          if (amp_pend) nxt = WR_AMP;
          else          nxt = ARM;
        end
      end
      WR_AMP: begin
        if (ph_tc) begin
          if (GAP_CYCLES > 0) nxt = GAP_A;
          else                nxt = ARM;
        end
      end
      GAP_A:   if (ph_tc) nxt = ARM;
      ARM:     nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // the phase timer restarts on every state change
  assign ph_load = (nxt != state);
  assign ph_val  = (nxt == WR_FREQ || nxt == WR_AMP) ? HOLD_LD : GAP_LD;

  osc_phase_timer #(.CNT_W(PH_W)) u_phase (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_load     (ph_load),
    .i_load_val (ph_val),
    .o_tc       (ph_tc)
  );

  // state, latched payload and all registered outputs
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state                <= IDLE;
      amp_pend             <= 1'b0;
      freq_q               <= '0;
      amp_q                <= '0;
      wave_q               <= '0;
      o_req_ready          <= 1'b0;
      o_busy               <= 1'b0;
      o_done               <= 1'b0;
      o_freq_en            <= 1'b0;
      o_amp_en             <= 1'b0;
      o_amplitude_freq_reg <= '0;
      o_wave_type_reg      <= '0;
      o_cur_freq           <= '0;
      o_cur_amp            <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        amp_pend <= i_req_mask[MASK_AMP];
        freq_q   <= i_req_freq;
        amp_q    <= i_req_amp;
        wave_q   <= i_req_wave;
      end
      o_req_ready <= (nxt == IDLE);
      o_busy      <= (nxt != IDLE);
      o_done      <= (nxt == DONE);
      // both enables together only in ARM, where the bus is forced to 0
      o_freq_en   <= (nxt == WR_FREQ) || (nxt == ARM);
      o_amp_en    <= (nxt == WR_AMP)  || (nxt == ARM);
      case (nxt)
        WR_FREQ: o_amplitude_freq_reg <= freq_n;
        WR_AMP:  o_amplitude_freq_reg <= amp_n;
        default: o_amplitude_freq_reg <= '0;
      endcase
      // wave lands with the arm cycle, or with done when nothing is written
      if (nxt == ARM || (accept && nxt == DONE)) o_wave_type_reg <= wave_n;
      if (state == WR_FREQ && ph_tc) o_cur_freq <= freq_q;
      if (state == WR_AMP  && ph_tc) o_cur_amp  <= amp_q;
    end
  end

endmodule
